// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants, types and syndrome helper for the (16,11) SECDED receiver
package hamming_pkg;

  localparam int CW_W   = 16;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;

  // Code positions that carry payload, listed in payload bit order
  localparam logic [SYN_W-1:0] P [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SED,
    ERR_DED
  } err_kind_e;

  typedef struct packed {
    logic [SYN_W-1:0] syn;
    logic             pe;
  } syn_t;

  // Syndrome is the XOR of the indices of all set bits; pe is overall parity
  function automatic syn_t hamming_syndrome(input logic [CW_W-1:0] cw);
    syn_t r;
    r.syn = '0;
    r.pe  = ^cw;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) r.syn = r.syn ^ SYN_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_sat_counter.sv
// rtl/hamming_sat_counter.sv - saturating event counter with clear
module hamming_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over a same-cycle increment; the count holds at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_secded_rx.sv
// rtl/hamming_secded_rx.sv - two-stage (16,11) SECDED receive pipeline; error statistics built only with HAMMING_RX_STATS_EN
module hamming_secded_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DROP_DED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sed,
  output logic              out_ded,
  output logic [SYN_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sed_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  input  logic              irq_clr,
  output logic              ded_irq
);

  // S1 keeps only the payload positions; parity positions are consumed by the syndrome
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_pe;

  syn_t              in_syn;
  logic [DATA_W-1:0] in_data;
  err_kind_e         s1_kind;
  logic [DATA_W-1:0] s1_fixed;
  logic              s2_can_load;
  logic              s2_enter;
  logic              s2_keep;
  logic              sed_inc;
  logic              ded_inc;

  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign s2_enter    = s1_valid && s2_can_load;
  assign s2_keep     = !((DROP_DED != 0) && (s1_kind == ERR_DED));
  assign sed_inc     = s2_enter && (s1_kind == ERR_SED);
  assign ded_inc     = s2_enter && (s1_kind == ERR_DED);

  // Syndrome, parity and raw payload gather for the incoming codeword
  always_comb begin
    in_syn  = hamming_syndrome(in_codeword);
    in_data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      in_data[k] = in_codeword[P[k]];
    end
  end

  // S1: capture syndrome stage whenever it is empty or draining into S2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_pe    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_syn  <= in_syn.syn;
        s1_pe   <= in_syn.pe;
      end
    end
  end

  // Classify and correct; a syndrome naming a parity position leaves the payload untouched
  always_comb begin
    s1_kind  = ERR_NONE;
    if (s1_pe) begin
      s1_kind = ERR_SED;
    end else if (s1_syn != '0) begin
      s1_kind = ERR_DED;
    end
    s1_fixed = s1_data;
    if (s1_kind == ERR_SED) begin
      for (int k = 0; k < DATA_W; k++) begin
        if (s1_syn == P[k]) s1_fixed[k] = ~s1_data[k];
      end
    end
  end

  // S2: output register; holds everything while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sed      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid && s2_keep;
      if (s1_valid && s2_keep) begin
        out_data     <= s1_fixed;
        out_sed      <= (s1_kind == ERR_SED);
        out_ded      <= (s1_kind == ERR_DED);
        out_syndrome <= s1_syn;
      end
    end
  end

`ifdef HAMMING_RX_STATS_EN
  hamming_sat_counter #(.CNT_W(CNT_W)) u_sed_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (sed_inc),
    .count (sed_cnt)
  );

  hamming_sat_counter #(.CNT_W(CNT_W)) u_ded_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (ded_inc),
    .count (ded_cnt)
  );

  // Sticky DED flag; a DED word entering S2 beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ded_irq <= 1'b0;
    end else if (ded_inc) begin
      ded_irq <= 1'b1;
    end else if (irq_clr) begin
      ded_irq <= 1'b0;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ^{cnt_clr, irq_clr, sed_inc, ded_inc};
  assign sed_cnt      = '0;
  assign ded_cnt      = '0;
  assign ded_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_secded_rx.sv
// tb/tb_hamming_secded_rx.sv - self-checking bench for hamming_secded_rx
module tb_hamming_secded_rx;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef HAMMING_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [15:0]         in_codeword = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [10:0]         out_data;
  logic                out_sed;
  logic                out_ded;
  logic [3:0]          out_syndrome;
  logic                cnt_clr = 1'b0;
  logic [TB_CNT_W-1:0] sed_cnt;
  logic [TB_CNT_W-1:0] ded_cnt;
  logic                irq_clr = 1'b0;
  logic                ded_irq;

  hamming_secded_rx #(.CNT_W(TB_CNT_W), .DROP_DED(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_codeword  (in_codeword),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sed      (out_sed),
    .out_ded      (out_ded),
    .out_syndrome (out_syndrome),
    .cnt_clr      (cnt_clr),
    .sed_cnt      (sed_cnt),
    .ded_cnt      (ded_cnt),
    .irq_clr      (irq_clr),
    .ded_irq      (ded_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] data;
    logic        sed;
    logic        ded;
    logic [3:0]  syn;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_sed = 0;
  int          exp_ded = 0;
  bit          exp_irq = 1'b0;
  bit          accepted = 1'b0;
  bit          hold_chk = 1'b0;
  bit          lat_chk = 1'b0;
  bit          last_in_ready = 1'b1;
  logic [16:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the code definition
  function automatic exp_t model(input logic [15:0] cw);
    exp_t        e;
    int          syn = 0;
    int          par = 0;
    int          k = 0;
    logic [15:0] c = cw;
    for (int i = 0; i < 16; i++) begin
      if (cw[i]) begin
        par ^= 1;
        syn ^= i;
      end
    end
    if (par != 0) c[syn] = ~c[syn];
    e.data = '0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        e.data[k] = c[i];
        k++;
      end
    end
    e.sed = (par != 0);
    e.ded = (par == 0) && (syn != 0);
    e.syn = 4'(syn);
    e.acc = 0;
    return e;
  endfunction

  // Random valid codeword with zero, one or two distinct bit flips
  function automatic logic [15:0] gen_cw();
    logic [15:0] c = '0;
    logic [10:0] d = 11'($urandom);
    int          k = 0;
    int          s = 0;
    int          nf;
    int          a;
    int          b;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int i = 1; i < 16; i++) if (c[i]) s ^= i;
    for (int j = 0; j < 4; j++) if (s[j]) c[1 << j] = 1'b1;
    c[0] = ^c;
    nf = int'($urandom_range(0, 2));
    a  = int'($urandom_range(0, 15));
    b  = (a + 1 + int'($urandom_range(0, 14))) % 16;
    if (nf >= 1) c[a] = ~c[a];
    if (nf == 2) c[b] = ~c[b];
    return c;
  endfunction

  // One clock: check at the falling edge, then step past the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (hold_chk) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({out_data, out_sed, out_ded, out_syndrome}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_sed", 32'(out_sed), 32'(e.sed));
          check("out_ded", 32'(out_ded), 32'(e.ded));
          check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
          if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd2);
        end
      end
      hold_chk      = out_valid && !out_ready;
      held          = {out_data, out_sed, out_ded, out_syndrome};
      last_in_ready = in_ready;
      accepted      = in_valid && in_ready;
      if (accepted) begin
        e     = model(in_codeword);
        e.acc = cyc;
        exp_q.push_back(e);
        if (e.sed && exp_sed < CNT_MAX) exp_sed++;
        if (e.ded) begin
          if (exp_ded < CNT_MAX) exp_ded++;
          exp_irq = 1'b1;
        end
      end
    end else begin
      accepted = 1'b0;
      hold_chk = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_one(input logic [15:0] cw);
    int n = 0;
    in_codeword = cw;
    in_valid    = 1'b1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 20);
    in_valid = 1'b0;
    check("accept_bound", 32'(accepted), 32'd1);
    drain();
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sed_cnt"}, 32'(sed_cnt), STATS ? 32'(exp_sed) : 32'd0);
    check({tag, "_ded_cnt"}, 32'(ded_cnt), STATS ? 32'(exp_ded) : 32'd0);
    check({tag, "_ded_irq"}, 32'(ded_irq), STATS ? 32'(exp_irq) : 32'd0);
  endtask

  // mode 0: continuous input with a 3-cycle consumer stall; mode 1: random gaps both sides
  task automatic stream(input int n, input int mode);
    int sent = 0;
    int c = 0;
    bit saw_bp = 1'b0;
    in_valid = 1'b0;
    while (sent < n && c < 400) begin
      if (!in_valid) begin
        in_valid    = (mode == 0) || ($urandom_range(0, 3) != 0);
        in_codeword = gen_cw();
      end
      if (mode == 0) out_ready = !(c >= 3 && c < 6);
      else           out_ready = ($urandom_range(0, 3) != 0);
      tick();
      c++;
      if (!last_in_ready) saw_bp = 1'b1;
      if (accepted) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 32'(sent), 32'(n));
    if (mode == 0) check("in_ready_dropped", 32'(saw_bp), 32'd1);
    drain();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sed", 32'(out_sed), 32'd0);
    check("rst_out_ded", 32'(out_ded), 32'd0);
    check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    check_stats("rst");
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Clean words with latency check
    lat_chk = 1'b1;
    send_one(16'h0000);
    check("clean0_data", 32'(out_data), 32'h000);
    check("clean0_flags", 32'({out_sed, out_ded}), 32'd0);
    send_one(16'hFFFF);
    check("clean1_data", 32'(out_data), 32'h7FF);
    check("clean1_flags", 32'({out_sed, out_ded}), 32'd0);

    // Single errors: payload bit and overall parity bit
    send_one(16'h0020);
    check("sed5_sed", 32'(out_sed), 32'd1);
    check("sed5_syn", 32'(out_syndrome), 32'd5);
    check("sed5_data", 32'(out_data), 32'h000);
    check("sed5_cnt", 32'(sed_cnt), STATS ? 32'd1 : 32'd0);
    send_one(16'hFFFE);
    check("sed0_sed", 32'(out_sed), 32'd1);
    check("sed0_syn", 32'(out_syndrome), 32'd0);
    check("sed0_data", 32'(out_data), 32'h7FF);

    // Double error, then irq clear racing a new DED word
    send_one(16'h0028);
    check("ded_ded", 32'(out_ded), 32'd1);
    check("ded_syn", 32'(out_syndrome), 32'd6);
    check("ded_data", 32'(out_data), 32'h003);
    check("ded_cnt1", 32'(ded_cnt), STATS ? 32'd1 : 32'd0);
    check("ded_irq1", 32'(ded_irq), STATS ? 32'd1 : 32'd0);
    in_codeword = 16'h0028;
    in_valid    = 1'b1;
    tick();
    check("irq_race_accept", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    irq_clr  = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_race_held", 32'(ded_irq), STATS ? 32'd1 : 32'd0);
    drain();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    exp_irq = 1'b0;
    check("irq_cleared", 32'(ded_irq), 32'd0);
    check_stats("after_irq");

    // Streams
    lat_chk = 1'b0;
    stream(8, 0);
    check_stats("stream8");
    stream(60, 1);
    check_stats("stream_rand");

    // Counter clear, saturation and clear-beats-increment
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_sed = 0;
    exp_ded = 0;
    check_stats("cnt_clr");
    for (int k = 1; k <= 5; k++) send_one(16'(1 << k));
    check("sed_saturated", 32'(sed_cnt), STATS ? 32'd3 : 32'd0);
    check_stats("sat");
    in_codeword = 16'h0040;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_sed = 0;
    exp_ded = 0;
    drain();
    check("clr_beats_inc", 32'(sed_cnt), 32'd0);

    // Reset with two words in flight
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_codeword = 16'h0028;
    tick();
    in_codeword = 16'h0020;
    tick();
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_sed   = 0;
    exp_ded   = 0;
    exp_irq   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    check_stats("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_secded_rx.md
Name: hamming_secded_rx

Overview:
- Streaming receive stage for (16,11) SECDED codewords.
- Sits between the link/deserializer and the consumer of 11-bit payloads.
- Accepts one codeword per cycle over a valid/ready handshake. Computes syndrome and overall parity, corrects single errors, flags double errors, and extracts the 11 data bits.
- Keeps error statistics and a sticky double-error interrupt.

Parameters:
- CNT_W, 16: width of SED/DED counters; counters saturate at 2^CNT_W-1.
- DROP_DED, 0: 1 = words with double errors are consumed but never presented on the output; 0 = forwarded with out_ded=1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  codeword valid.
- in_ready  out  1  stage can accept; transfer when in_valid&&in_ready.
- in_codeword  in  16  bit i = code position i; bit 0 is the overall parity; bits 1,2,4,8 are Hamming parity.
- out_valid  out  1  payload valid.
- out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready.
- out_data  out  11  extracted (corrected) data.
- out_sed  out  1  single error was corrected in this word.
- out_ded  out  1  uncorrectable double error in this word.
- out_syndrome  out  4  raw 4-bit syndrome of this word.
- cnt_clr  in  1  clear both counters.
- sed_cnt  out  CNT_W  saturating count of SED words accepted.
- ded_cnt  out  CNT_W  saturating count of DED words accepted.
- irq_clr  in  1  clear ded_irq.
- ded_irq  out  1  sticky; set on any accepted DED word.

Behaviour:
- Reset: all pipeline valids, counters, and ded_irq go to 0. out_data, out_sed, out_ded and out_syndrome go to 0. in_ready is 1 in the cycle after reset deasserts.
- A reset mid-stream discards all in-flight words.

Pipeline:
- Two register stages, S1 (syndrome) and S2 (correct/extract).
- Latency is 2 cycles from the accept edge to out_valid. Full throughput is 1 word/cycle.
- Each stage loads when it is empty or its content is leaving that cycle.
- in_ready = !s1_valid || s2_can_load, combinational from out_ready.
- No combinational path from in_valid to out_valid.

Outputs under backpressure:
- While out_valid && !out_ready, all out_* signals are held stable.

S1 captures:
- The codeword.
- syndrome s = XOR of indices i (1..15) where in_codeword[i]=1.
- overall parity pe = XOR of all 16 bits.

S2 classification:
- pe=0, s=0: clean.
- pe=1: SED. Flip bit s; s=0 means bit 0 flipped, so the data is unaffected.
- pe=0, s!=0: DED. No correction; data passed raw.

Data extraction:
- out_data[k] = corrected bit at position P[k].
- P = {3,5,6,7,9,10,11,12,13,14,15} for k=0..10.

DROP_DED=1:
- A DED word is retired from S2 without asserting out_valid.
- Counters and irq still update.

Counters and interrupt:
- Counters and irq update when the word enters S2, i.e. once per accepted word regardless of backpressure.
- Counters saturate and never wrap.
- cnt_clr has priority over a same-cycle increment; the result is 0.
- For ded_irq, a same-cycle set beats irq_clr, so the irq stays 1.

Optional Feature:
- Macro HAMMING_RX_STATS_EN.
- Defined: sed_cnt, ded_cnt and ded_irq behave as above.
- Undefined: the counter and irq registers are not built. sed_cnt, ded_cnt and ded_irq are tied to 0. cnt_clr and irq_clr are ignored.
- Datapath behaviour is identical in both cases.

Decomposition:
- Package hamming_pkg holds:
  - CW_W=16, DATA_W=11, SYN_W=4.
  - the data-position constant array P.
  - typedef enum err_kind_e {ERR_NONE, ERR_SED, ERR_DED}.
  - function hamming_syndrome(codeword) returning the syndrome and parity.
- One sub-module, hamming_sat_counter (CNT_W, clr, inc), instantiated twice.

Test Plan:
- Send 0x0000, then 0xFFFF, with out_ready=1. Required: out_data=0x000 then 0x7FF; both words clean; out_valid arrives 2 cycles after each accept.
- Send 0x0020 (bit 5 flipped). Required: out_sed=1, out_syndrome=5, out_data=0x000, sed_cnt=1.
- Send 0xFFFE (bit 0 flipped). Required: out_sed=1, out_syndrome=0, out_data=0x7FF.
- Send 0x0028 with DROP_DED=0. Required: out_ded=1, out_syndrome=6, ded_cnt=1, ded_irq=1. Then pulse irq_clr in the same cycle as another DED word; ded_irq must stay 1.
- Back-to-back stream of 8 words with out_ready low for 3 cycles mid-stream. Required: in_ready drops once both stages are full; no word is lost or duplicated; output order is preserved; out_* are stable while stalled.
- Drive sed_cnt to saturation using CNT_W=2: 5 SED words give 3. Also assert rst with 2 words in flight: no out_valid afterwards, counters are 0.
